my_slave_mem: RTL

//  Responder (slave) end of the my_if request/response bus: word-addressed RAM plus 3 CSRs.

---
 rtl/my_slave_pkg.sv | 26 ++
 rtl/my_slave_csr.sv | 72 +++++++
 rtl/my_slave_mem.sv | 112 +++++++++++
 3 files changed

// File: rtl/my_slave_pkg.sv
// -----------------------------------------------------------------------------
// my_slave_pkg
// Shared definitions for the my_if responder (my_slave_mem):
//   - CSR byte offsets relative to the CSR block base
//   - bit position of the write-protect flag inside CTRL
//   - address decode result type used by the top level and the CSR block
// -----------------------------------------------------------------------------
package my_slave_pkg;

    localparam logic [31:0] CTRL_OFS    = 32'h0000_0000;
    localparam logic [31:0] ERR_OFS     = 32'h0000_0004;
    localparam logic [31:0] ACC_OFS     = 32'h0000_0008;
    localparam int          CTRL_WP_BIT = 0;

    // Error counter saturates here instead of wrapping.
    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        DEC_RAM,
        DEC_CTRL,
        DEC_ERR,
        DEC_ACC,
        DEC_BAD
    } dec_e;

endpackage : my_slave_pkg

// File: rtl/my_slave_csr.sv
// -----------------------------------------------------------------------------
// my_slave_csr
// Control/status registers of the my_if responder.
//   CTRL    : bit0 = WP (write-protect RAM), other bits read 0
//   ERR_CNT : 16-bit saturating error counter, any write clears it
//   ACC_CNT : 32-bit wrapping count of successful accesses, read-only
// Ports:
//   clk        in   clock, all state on posedge
//   rst        in   synchronous reset, active-high
//   write      in   request is a write
//   dec        in   decoded target of the current request
//   wp_wdata   in   write-data bit that lands in CTRL.WP
//   acc_ok     in   strobe: current request succeeds (already gated by SEL/RST)
//   acc_err    in   strobe: current request fails   (already gated by SEL/RST)
//   wp         out  current write-protect flag
//   csr_rdata  out  read data of the addressed CSR (pre-update values)
// -----------------------------------------------------------------------------
module my_slave_csr
    import my_slave_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        write,
    input  dec_e        dec,
    input  logic        wp_wdata,
    input  logic        acc_ok,
    input  logic        acc_err,
    output logic        wp,
    output logic [31:0] csr_rdata
);

    logic [15:0] err_cnt;
    logic [31:0] acc_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; reads in the same cycle see old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= 1'b0;
            err_cnt <= '0;
            acc_cnt <= '0;
        end else begin
            if (acc_ok && write && dec == DEC_CTRL) begin
                wp <= wp_wdata;
            end

            if (acc_ok && write && dec == DEC_ERR) begin
                err_cnt <= '0;
            end else if (acc_err && err_cnt != ERR_CNT_MAX) begin
                err_cnt <= err_cnt + 16'd1;
            end

            // Natural 32-bit wrap from all-ones back to zero.
            if (acc_ok) begin
                acc_cnt <= acc_cnt + 32'd1;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is
    // inferred on the decode paths that do not select a CSR.
    always_comb begin
        csr_rdata = '0;
        unique case (dec)
            DEC_CTRL: csr_rdata[CTRL_WP_BIT] = wp;
            DEC_ERR:  csr_rdata = {16'b0, err_cnt};
            DEC_ACC:  csr_rdata = acc_cnt;
            default:  csr_rdata = '0;
        endcase
    end

endmodule : my_slave_csr

// File: rtl/my_slave_mem.sv
// -----------------------------------------------------------------------------
// my_slave_mem
// Responder end of the my_if request/response bus: word-addressed RAM plus
// three CSRs (CTRL, ERR_CNT, ACC_CNT). One request per cycle, zero wait
// states; the response is registered and visible in the cycle after the
// request edge.
// Ports:
//   CLK       in   clock, all logic on posedge
//   RST       in   synchronous reset, active-high; drops the sampled request
//   SEL       in   request valid this cycle
//   WRITE     in   1 = write, 0 = read (qualified by SEL)
//   ADDR      in   byte address
//   WDATA     in   write data
//   RDATA     out  read data (0 for writes and errors)
//   OKAY      out  1 = request succeeded
//   RESP_VLD  out  SEL delayed one cycle, for checkers
// -----------------------------------------------------------------------------
module my_slave_mem
    import my_slave_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] CSR_ADDR  = 32'h0000_1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SEL,
    input  logic        WRITE,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        OKAY,
    output logic        RESP_VLD
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    dec_e          dec;
    logic          req_err;
    logic          acc_ok;
    logic          acc_err;
    logic          wp;
    logic [31:0]   csr_rdata;
    logic [31:0]   rd_data;
    logic [AW-1:0] ram_idx;
    logic [31:0]   mem [DEPTH];

    assign ram_idx = ADDR[AW+1:2];

    // Address decode. The RAM window test uses an unsigned offset so that
    // addresses below BASE_ADDR wrap to a large value and fall outside.
    always_comb begin
        dec = DEC_BAD;
        if (ADDR[1:0] == 2'b00) begin
            if ((ADDR - BASE_ADDR) < RAM_BYTES) begin
                dec = DEC_RAM;
            end else if (ADDR == CSR_ADDR + CTRL_OFS) begin
                dec = DEC_CTRL;
            end else if (ADDR == CSR_ADDR + ERR_OFS) begin
                dec = DEC_ERR;
            end else if (ADDR == CSR_ADDR + ACC_OFS) begin
                dec = DEC_ACC;
            end
        end
    end

    // Unmapped/misaligned, protected RAM write, or write to read-only ACC_CNT.
    assign req_err = (dec == DEC_BAD)
                   || (WRITE && dec == DEC_RAM && wp)
                   || (WRITE && dec == DEC_ACC);

    // A request sampled during reset is dropped: no strobes, no updates.
    assign acc_ok  = SEL && !RST && !req_err;
    assign acc_err = SEL && !RST &&  req_err;

    my_slave_csr u_csr (
        .clk       (CLK),
        .rst       (RST),
        .write     (WRITE),
        .dec       (dec),
        .wp_wdata  (WDATA[CTRL_WP_BIT]),
        .acc_ok    (acc_ok),
        .acc_err   (acc_err),
        .wp        (wp),
        .csr_rdata (csr_rdata)
    );

    // NOTE: the RAM array is deliberately left out of reset; clearing a memory
    // needs a sequencer, and only the registers around it must start defined.
    always_ff @(posedge CLK) begin
        if (acc_ok && WRITE && dec == DEC_RAM) begin
            mem[ram_idx] <= WDATA;
        end
    end

    assign rd_data = (dec == DEC_RAM) ? mem[ram_idx] : csr_rdata;

    // Response registers; writes and errors return zero data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RDATA    <= '0;
            OKAY     <= 1'b0;
            RESP_VLD <= 1'b0;
        end else begin
            RESP_VLD <= SEL;
            OKAY     <= acc_ok;
            RDATA    <= (acc_ok && !WRITE) ? rd_data : 32'h0;
        end
    end

endmodule : my_slave_mem
